// File: rtl/attack_phase_sequencer_pkg.sv
// Shared player definitions: phase state encoding, attack kind encoding and
// the default phase limits used by the attack phase sequencer.
package attack_phase_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STARTUP  = 3'd1,
    ST_ACTIVE   = 3'd2,
    ST_RECOVERY = 3'd3,
    ST_HITSTUN  = 3'd4
  } state_t;

  typedef enum logic {
    KIND_BASIC       = 1'b0,
    KIND_DIRECTIONAL = 1'b1
  } kind_t;

  localparam int DEF_WIDTH      = 5;
  localparam int DEF_B_STARTUP  = 5;
  localparam int DEF_B_ACTIVE   = 2;
  localparam int DEF_B_RECOVERY = 16;
  localparam int DEF_D_STARTUP  = 4;
  localparam int DEF_D_ACTIVE   = 3;
  localparam int DEF_D_RECOVERY = 15;
  localparam int DEF_HITSTUN    = 20;

endpackage

// File: rtl/attack_phase_sequencer.sv
// Per-player attack/stun phase controller. Drives the sibling duration counter
// (enable/stop/limit) and advances phases on its done pulse.
module attack_phase_sequencer
  import attack_phase_sequencer_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int B_STARTUP  = DEF_B_STARTUP,
  parameter int B_ACTIVE   = DEF_B_ACTIVE,
  parameter int B_RECOVERY = DEF_B_RECOVERY,
  parameter int D_STARTUP  = DEF_D_STARTUP,
  parameter int D_ACTIVE   = DEF_D_ACTIVE,
  parameter int D_RECOVERY = DEF_D_RECOVERY,
  parameter int HITSTUN    = DEF_HITSTUN
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             i_attack,
  input  logic             i_kind,
  input  logic             i_hit,
  input  logic             i_cnt_done,
  output logic             o_cnt_enable,
  output logic             o_cnt_stop,
  output logic [WIDTH-1:0] o_cnt_limit,
  output logic [2:0]       o_state,
  output logic             o_busy,
  output logic             o_hitbox,
  output logic             o_stunned,
  output logic             o_seq_done
);

  // Truncate to the counter width first, then keep a zero limit from stalling.
  function automatic logic [WIDTH-1:0] clamp_limit(input int value);
    logic [WIDTH-1:0] trunc;
    trunc = value[WIDTH-1:0];
    return (trunc == '0) ? WIDTH'(1) : trunc;
  endfunction

  function automatic logic [WIDTH-1:0] phase_limit(input state_t st, input kind_t kind);
    logic [WIDTH-1:0] result;
    result = WIDTH'(1);
    case (st)
      ST_STARTUP:  result = clamp_limit((kind == KIND_DIRECTIONAL) ? D_STARTUP  : B_STARTUP);
      ST_ACTIVE:   result = clamp_limit((kind == KIND_DIRECTIONAL) ? D_ACTIVE   : B_ACTIVE);
      ST_RECOVERY: result = clamp_limit((kind == KIND_DIRECTIONAL) ? D_RECOVERY : B_RECOVERY);
      ST_HITSTUN:  result = clamp_limit(HITSTUN);
      default:     result = WIDTH'(1);
    endcase
    return result;
  endfunction

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             enable_q, enable_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic             hitbox_q, hitbox_d;
  logic             stunned_q, stunned_d;
  logic             seq_done_q, seq_done_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d    = state_q;
    kind_d     = kind_q;
    limit_d    = limit_q;
    enable_d   = enable_q;
    stop_d     = 1'b0;
    seq_done_d = 1'b0;

    if (i_hit) begin
      state_d  = ST_HITSTUN;
      limit_d  = phase_limit(ST_HITSTUN, kind_q);
      enable_d = 1'b1;
      stop_d   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_attack) begin
            kind_d   = kind_t'(i_kind);
            state_d  = ST_STARTUP;
            limit_d  = phase_limit(ST_STARTUP, kind_t'(i_kind));
            enable_d = 1'b1;
          end
        end
        ST_STARTUP: begin
          if (i_cnt_done) begin
            state_d = ST_ACTIVE;
            limit_d = phase_limit(ST_ACTIVE, kind_q);
          end
        end
        ST_ACTIVE: begin
          if (i_cnt_done) begin
            state_d = ST_RECOVERY;
            limit_d = phase_limit(ST_RECOVERY, kind_q);
          end
        end
        ST_RECOVERY: begin
          if (i_cnt_done) begin
            state_d    = ST_IDLE;
            enable_d   = 1'b0;
            seq_done_d = 1'b1;
          end
        end
        ST_HITSTUN: begin
          // A done seen during the stop cycle belongs to the preempted phase.
          if (i_cnt_done && !stop_q) begin
            state_d  = ST_IDLE;
            enable_d = 1'b0;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          enable_d = 1'b0;
        end
      endcase
    end

    busy_d    = (state_d != ST_IDLE);
    hitbox_d  = (state_d == ST_ACTIVE);
    stunned_d = (state_d == ST_HITSTUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (nRst) begin
      state_q    <= ST_IDLE;
      kind_q     <= KIND_BASIC;
      limit_q    <= WIDTH'(1);
      enable_q   <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
      hitbox_q   <= 1'b0;
      stunned_q  <= 1'b0;
      seq_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      limit_q    <= limit_d;
      enable_q   <= enable_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
      hitbox_q   <= hitbox_d;
      stunned_q  <= stunned_d;
      seq_done_q <= seq_done_d;
    end
  end

  assign o_state      = state_q;
  assign o_cnt_limit  = limit_q;
  assign o_cnt_enable = enable_q;
  assign o_cnt_stop   = stop_q;
  assign o_busy       = busy_q;
  assign o_hitbox     = hitbox_q;
  assign o_stunned    = stunned_q;
  assign o_seq_done   = seq_done_q;

endmodule

// File: tb/tb_attack_phase_sequencer.sv
// Directed bench for attack_phase_sequencer; a behavioural duration counter
// closes the enable/stop/limit/done handshake for each instance.
module tb_attack_phase_sequencer;
  import attack_phase_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nRst = 1'b1;
  logic       i_attack = 1'b0, i_kind = 1'b0, i_hit = 1'b0;
  logic       i_attack2 = 1'b0, i_hit2 = 1'b0;
  logic       en1, stop1, busy1, hitbox1, stunned1, sd1, done1;
  logic       en2, stop2, busy2, hitbox2, stunned2, sd2, done2;
  logic [4:0] lim1, lim2;
  logic [2:0] st1, st2;
  logic [4:0] cnt1 = '0, cnt2 = '0;

  int vectors = 0;
  int miscompares = 0;

  attack_phase_sequencer dut (
    .clk(clk), .nRst(nRst), .i_attack(i_attack), .i_kind(i_kind), .i_hit(i_hit),
    .i_cnt_done(done1), .o_cnt_enable(en1), .o_cnt_stop(stop1), .o_cnt_limit(lim1),
    .o_state(st1), .o_busy(busy1), .o_hitbox(hitbox1), .o_stunned(stunned1),
    .o_seq_done(sd1)
  );

  attack_phase_sequencer #(.B_ACTIVE(0)) dut_clamp (
    .clk(clk), .nRst(nRst), .i_attack(i_attack2), .i_kind(1'b0), .i_hit(i_hit2),
    .i_cnt_done(done2), .o_cnt_enable(en2), .o_cnt_stop(stop2), .o_cnt_limit(lim2),
    .o_state(st2), .o_busy(busy2), .o_hitbox(hitbox2), .o_stunned(stunned2),
    .o_seq_done(sd2)
  );

  // Peer duration counter: counts from 0 while enabled, done when count == limit,
  // self-clears after done, synchronous clear on stop or reset.
  assign done1 = en1 && !stop1 && (cnt1 == lim1);
  assign done2 = en2 && !stop2 && (cnt2 == lim2);

  always @(posedge clk) begin
    if (nRst || stop1 || done1) cnt1 <= '0;
    else if (en1)               cnt1 <= cnt1 + 5'd1;
    if (nRst || stop2 || done2) cnt2 <= '0;
    else if (en2)               cnt2 <= cnt2 + 5'd1;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish before time limit");
    $fatal(1);
  end

  // Expected output vector {state, limit, enable, stop, busy, hitbox, stunned, seq_done}.
  function automatic logic [13:0] pack(input logic [2:0] st, input logic [4:0] lim,
                                       input logic en, input logic stop, input logic sd);
    return {st, lim, en, stop, st != 3'd0, st == 3'd2, st == 3'd4, sd};
  endfunction

  function automatic logic [13:0] obs1();
    return {st1, lim1, en1, stop1, busy1, hitbox1, stunned1, sd1};
  endfunction

  // Expected output of an undisturbed attack in cycle c (cycle 1 = first STARTUP cycle).
  function automatic logic [13:0] attack_vec(input int c, input int ls, input int la, input int lr);
    int total;
    total = ls + la + lr + 3;
    if (c <= ls + 1)           return pack(3'd1, 5'(ls), 1'b1, 1'b0, 1'b0);
    if (c <= ls + la + 2)      return pack(3'd2, 5'(la), 1'b1, 1'b0, 1'b0);
    if (c <= total)            return pack(3'd3, 5'(lr), 1'b1, 1'b0, 1'b0);
    if (c == total + 1)        return pack(3'd0, 5'(lr), 1'b0, 1'b0, 1'b1);
    return pack(3'd0, 5'(lr), 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic test_reset();
    logic [13:0] exp;
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    exp = pack(3'd0, 5'd1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (obs1() !== exp) begin
      miscompares++;
      $display("FAIL reset_held: got %b required %b", obs1(), exp);
    end
    nRst = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs1() !== exp) begin
      miscompares++;
      $display("FAIL reset_released: got %b required %b", obs1(), exp);
    end
  endtask

  // Runs one attack; optionally pulses i_attack at cycle pulse_at or holds it for a re-trigger.
  task automatic run_attack(input string name, input logic kind, input int ls, input int la,
                            input int lr, input int pulse_at, input bit hold);
    int total;
    logic [13:0] exp;
    total = ls + la + lr + 3;
    i_attack = 1'b1;
    i_kind   = kind;
    @(negedge clk);
    for (int c = 1; c <= total + 2; c++) begin
      if (c == pulse_at) begin
        i_attack = 1'b1;
        i_kind   = ~kind;
      end else begin
        i_attack = hold;
        i_kind   = kind;
      end
      if (hold && c == total + 2) exp = pack(3'd1, 5'(ls), 1'b1, 1'b0, 1'b0);
      else                        exp = attack_vec(c, ls, la, lr);
      vectors++;
      if (obs1() !== exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %b required %b", name, c, obs1(), exp);
      end
      @(negedge clk);
    end
    i_attack = 1'b0;
    if (hold) begin
      for (int i = 0; i < 40 && busy1; i++) @(negedge clk);
      vectors++;
      if (busy1 !== 1'b0) begin
        miscompares++;
        $display("FAIL %s drain: got busy %b required 0", name, busy1);
      end
      @(negedge clk);
    end
  endtask

  // Basic attack hit at cycle hit_at: 22 HITSTUN cycles follow, then IDLE without seq_done.
  task automatic test_hit(input string name, input int hit_at, input bit expect_done_then);
    logic [13:0] exp;
    i_attack = 1'b1;
    i_kind   = 1'b0;
    @(negedge clk);
    i_attack = 1'b0;
    for (int c = 1; c <= hit_at + 23; c++) begin
      i_hit = (c == hit_at);
      if (c <= hit_at)           exp = attack_vec(c, 5, 2, 16);
      else if (c <= hit_at + 22) exp = pack(3'd4, 5'd20, 1'b1, c == hit_at + 1, 1'b0);
      else                       exp = pack(3'd0, 5'd20, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs1() !== exp) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %b required %b", name, c, obs1(), exp);
      end
      if (c == hit_at) begin
        vectors++;
        if (done1 !== expect_done_then) begin
          miscompares++;
          $display("FAIL %s done_at_hit: got %b required %b", name, done1, expect_done_then);
        end
      end
      @(negedge clk);
    end
    i_hit = 1'b0;
  endtask

  task automatic test_hit_with_attack_in_idle();
    logic [13:0] exp;
    i_attack = 1'b1;
    i_hit    = 1'b1;
    @(negedge clk);
    i_attack = 1'b0;
    i_hit    = 1'b0;
    for (int c = 1; c <= 23; c++) begin
      if (c <= 22) exp = pack(3'd4, 5'd20, 1'b1, c == 1, 1'b0);
      else         exp = pack(3'd0, 5'd20, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs1() !== exp) begin
        miscompares++;
        $display("FAIL hit_attack_idle cycle %0d: got %b required %b", c, obs1(), exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_recovery();
    logic [13:0] exp;
    i_attack = 1'b1;
    i_kind   = 1'b0;
    @(negedge clk);
    i_attack = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      nRst = (c == 15);
      if (c <= 15) exp = attack_vec(c, 5, 2, 16);
      else         exp = pack(3'd0, 5'd1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (obs1() !== exp) begin
        miscompares++;
        $display("FAIL reset_mid cycle %0d: got %b required %b", c, obs1(), exp);
      end
      @(negedge clk);
    end
    nRst = 1'b0;
  endtask

  // B_ACTIVE = 0 clamps to 1, so ACTIVE lasts two cycles and the attack 25 busy cycles.
  task automatic test_clamp();
    int active_cycles;
    logic [2:0] exp_st;
    logic [4:0] exp_lim;
    active_cycles = 0;
    i_attack2 = 1'b1;
    @(negedge clk);
    i_attack2 = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      if (c <= 6)       begin exp_st = 3'd1; exp_lim = 5'd5;  end
      else if (c <= 8)  begin exp_st = 3'd2; exp_lim = 5'd1;  end
      else if (c <= 25) begin exp_st = 3'd3; exp_lim = 5'd16; end
      else              begin exp_st = 3'd0; exp_lim = 5'd16; end
      if (hitbox2) active_cycles++;
      vectors++;
      if (st2 !== exp_st || lim2 !== exp_lim || sd2 !== (c == 26)) begin
        miscompares++;
        $display("FAIL clamp cycle %0d: got state %0d limit %0d seq_done %b required state %0d limit %0d seq_done %b",
                 c, st2, lim2, sd2, exp_st, exp_lim, c == 26);
      end
      @(negedge clk);
    end
    vectors++;
    if (active_cycles != 2) begin
      miscompares++;
      $display("FAIL clamp_active_len: got %0d cycles required 2", active_cycles);
    end
  endtask

  initial begin
    test_reset();
    run_attack("basic", 1'b0, 5, 2, 16, 0, 1'b0);
    run_attack("directional", 1'b1, 4, 3, 15, 0, 1'b0);
    run_attack("ignored_request", 1'b0, 5, 2, 16, 12, 1'b0);
    run_attack("back_to_back", 1'b0, 5, 2, 16, 0, 1'b1);
    test_hit("preempt_active", 8, 1'b0);
    test_hit("hit_with_done", 6, 1'b1);
    test_hit_with_attack_in_idle();
    test_reset_mid_recovery();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
